spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master controller: one full-duplex word per start request.
// Configuration is latched when a transfer is accepted. cs frames the transfer
// with programmable setup/hold times and is forced high for at least two
// cycles between transfers. All four SPI modes are supported, in either bit order.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  start,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  msb_first,
  input  logic [7:0]            baud_div,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  sclk,
  output logic                  cs,
  output logic                  mosi0,
  input  logic                  miso0
);

  localparam int             EW         = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0]  LAST_EDGE  = EW'(2 * DATA_WIDTH);
  localparam logic [3:0]     SETUP_LAST = 4'(CS_SETUP - 1);
  localparam logic [3:0]     HOLD_LAST  = 4'(CS_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, GAP} state_t;

  state_t                state_q, state_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  msb_q, msb_d;
  logic [7:0]            baud_q, baud_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [7:0]            div_cnt_q, div_cnt_d;
  logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
  logic [3:0]            ph_cnt_q, ph_cnt_d;

  // Bit-order helpers for the latched transmit/receive shifters.
  logic                  tx_out;
  logic [DATA_WIDTH-1:0] tx_shifted;
  logic [DATA_WIDTH-1:0] rx_shifted;
  assign tx_out     = msb_q ? tx_sh_q[DATA_WIDTH-1] : tx_sh_q[0];
  assign tx_shifted = msb_q ? {tx_sh_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_sh_q[DATA_WIDTH-1:1]};
  assign rx_shifted = msb_q ? {rx_sh_q[DATA_WIDTH-2:0], miso0} : {miso0, rx_sh_q[DATA_WIDTH-1:1]};

  assign ready    = (state_q == IDLE);
  assign cs       = (state_q == IDLE) || (state_q == GAP);
  assign sclk     = sclk_q;
  assign mosi0    = mosi_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  // State and datapath registers; reset aborts any transfer without a valid pulse.
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      msb_q      <= 1'b0;
      baud_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      ph_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      msb_q      <= msb_d;
      baud_q     <= baud_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ph_cnt_q   <= ph_cnt_d;
    end
  end

  // Next-state logic: framing phases, sclk divider, and shift/sample on sclk edges.
  always_comb begin
    logic [EW-1:0] edge_num;
    logic          leading;
    logic          do_sample;
    logic          do_shift;
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    msb_d      = msb_q;
    baud_d     = baud_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ph_cnt_d   = ph_cnt_q;
    edge_num   = edge_cnt_q + 1'b1;
    // Edges are numbered from 1: odd edges lead, even edges trail.
    leading    = ~edge_cnt_q[0];
    do_sample  = 1'b0;
    do_shift   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETUP;
          cpol_d   = cpol;
          cpha_d   = cpha;
          msb_d    = msb_first;
          baud_d   = baud_div;
          sclk_d   = cpol;
          ph_cnt_d = '0;
          rx_sh_d  = '0;
          if (!cpha) begin
            // Mode with cpha=0 needs the first bit on the wire before the first edge.
            mosi_d  = msb_first ? tx_data[DATA_WIDTH-1] : tx_data[0];
            tx_sh_d = msb_first ? {tx_data[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_data[DATA_WIDTH-1:1]};
          end else begin
            mosi_d  = 1'b0;
            tx_sh_d = tx_data;
          end
        end
      end
      SETUP: begin
        if (ph_cnt_q == SETUP_LAST) begin
          state_d    = TRANSFER;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 4'd1;
        end
      end
      TRANSFER: begin
        if (div_cnt_q == baud_q) begin
          div_cnt_d  = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_num;
          do_sample  = cpha_q ? ~leading : leading;
          // With cpha=0 the final trailing edge has no further bit to present.
          do_shift   = cpha_q ? leading : (~leading && (edge_num != LAST_EDGE));
          if (do_sample) begin
            rx_sh_d = rx_shifted;
          end
          if (do_shift) begin
            mosi_d  = tx_out;
            tx_sh_d = tx_shifted;
          end
          if (edge_num == LAST_EDGE) begin
            state_d  = HOLD;
            ph_cnt_d = '0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (ph_cnt_q == HOLD_LAST) begin
          state_d    = GAP;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end else begin
          ph_cnt_d = ph_cnt_q + 4'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
        mosi_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a bus-level slave model drives miso0,
// each transfer is observed on the SPI pins and checked against hand values.
module tb_spi_master_ctrl;

  logic       pclk = 1'b0;
  logic       areset, start, cpol, cpha, msb_first;
  logic [7:0] tx_data, baud_div, rx_data;
  logic       ready, rx_valid, sclk, cs, mosi0, miso0;

  int n_checks = 0;
  int n_errors = 0;

  // Slave model configuration and state.
  logic       sl_cpol = 1'b0, sl_cpha = 1'b0, sl_msb = 1'b1, sl_loop = 1'b0;
  logic [7:0] sl_pat = 8'h00;
  logic       sl_bit = 1'b0, sl_prev = 1'b0;
  int         sl_idx = 0, sl_e = 0;

  // Per-transfer observations.
  logic [7:0] r_mosi, r_rx;
  logic       r_first, r_sclk_end;
  int         r_edges, r_valid, r_lat, r_cs_low, r_gmin, r_gmax;

  spi_master_ctrl #(.DATA_WIDTH(8), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .pclk(pclk), .areset(areset), .start(start), .ready(ready),
    .tx_data(tx_data), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
    .baud_div(baud_div), .rx_data(rx_data), .rx_valid(rx_valid),
    .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0)
  );

  always #5 pclk = ~pclk;

  assign miso0 = sl_loop ? mosi0 : sl_bit;

  function automatic logic bitof(input int i);
    if (i > 7) return 1'b0;
    return sl_msb ? sl_pat[7-i] : sl_pat[i];
  endfunction

  // Slave: presents its pattern, shifting on the edges opposite to the master's sampling edges.
  always @(negedge pclk) begin
    if (cs) begin
      sl_idx  = 0;
      sl_e    = 0;
      sl_prev = sl_cpol;
      sl_bit  = sl_cpha ? 1'b0 : bitof(0);
    end else if (sclk != sl_prev) begin
      sl_prev = sclk;
      sl_e++;
      if ((sl_e % 2 == 1) && sl_cpha) begin
        sl_bit = bitof(sl_idx);
        sl_idx++;
      end else if ((sl_e % 2 == 0) && !sl_cpha) begin
        sl_idx++;
        sl_bit = bitof(sl_idx);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer; p_chg >= 0 scrambles all inputs and pulses start at that cycle.
  task automatic run_xfer(input logic p_cpol, input logic p_cpha, input logic p_msb,
                          input logic [7:0] p_bd, input logic [7:0] p_tx,
                          input logic [7:0] p_pat, input logic p_loop, input int p_chg);
    logic prev;
    int   last;
    bit   done;
    sl_cpol = p_cpol; sl_cpha = p_cpha; sl_msb = p_msb; sl_pat = p_pat; sl_loop = p_loop;
    cpol = p_cpol; cpha = p_cpha; msb_first = p_msb; baud_div = p_bd; tx_data = p_tx;
    @(negedge pclk);
    start = 1'b1;
    @(posedge pclk);
    r_mosi = 8'h00; r_rx = 8'h00; r_first = 1'b0; r_sclk_end = 1'b0;
    r_edges = 0; r_valid = 0; r_lat = -1; r_cs_low = 0; r_gmin = 100000; r_gmax = 0;
    prev = p_cpol; last = 0; done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge pclk);
      if (t == 0) begin
        start   = 1'b0;
        r_first = mosi0;
      end
      if (t == p_chg) begin
        tx_data = ~p_tx; cpol = ~p_cpol; cpha = ~p_cpha; msb_first = ~p_msb;
        baud_div = 8'd0; start = 1'b1;
      end
      if (p_chg >= 0 && t == p_chg + 1) start = 1'b0;
      if (!cs) r_cs_low++;
      if (sclk != prev) begin
        prev = sclk;
        r_edges++;
        if (r_edges > 1) begin
          if (t - last < r_gmin) r_gmin = t - last;
          if (t - last > r_gmax) r_gmax = t - last;
        end
        last = t;
        if ((r_edges % 2 == 1) == (p_cpha == 1'b0)) r_mosi = {r_mosi[6:0], mosi0};
      end
      if (rx_valid) begin
        r_valid++;
        if (r_valid == 1) begin
          r_lat = t; r_rx = rx_data; r_sclk_end = sclk;
        end
      end
      if (r_valid > 0 && ready) done = 1'b1;
    end
    check("xfer_done", done, 1'b1);
    $display("xfer cpol=%0d cpha=%0d msb=%0d div=%0d tx=%02h mosi=%02h rx=%02h lat=%0d edges=%0d",
             p_cpol, p_cpha, p_msb, p_bd, p_tx, r_mosi, r_rx, r_lat, r_edges);
  endtask

  initial begin
    logic prev;
    int   edges, vcnt, v1, v2, cs_hi;
    logic [7:0] rx2;

    areset = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1;
    tx_data = 8'h00; baud_div = 8'h00;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_ready", ready, 1'b1);
    check("rst_cs", cs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi0, 1'b0);
    check("rst_rxv", rx_valid, 1'b0);
    check("rst_rxd", rx_data, 8'h00);
    areset = 1'b0;
    @(negedge pclk);

    // Mode 0, loopback, 0xA5 MSB first, fastest clock.
    run_xfer(1'b0, 1'b0, 1'b1, 8'd0, 8'hA5, 8'h00, 1'b1, -1);
    check("m0_first", r_first, 1'b1);
    check("m0_mosi", r_mosi, 8'hA5);
    check("m0_rx", r_rx, 8'hA5);
    check("m0_lat", r_lat, 20);
    check("m0_vcnt", r_valid, 1);
    check("m0_edges", r_edges, 16);
    check("m0_cslow", r_cs_low, 20);
    check("m0_gmin", r_gmin, 1);
    check("m0_gmax", r_gmax, 1);
    check("m0_sclk_end", r_sclk_end, 1'b0);
    check("m0_mosi_idle", mosi0, 1'b0);

    // Mode 3, divider 3, slave returns 0x96.
    run_xfer(1'b1, 1'b1, 1'b1, 8'd3, 8'h3C, 8'h96, 1'b0, -1);
    check("m3_mosi", r_mosi, 8'h3C);
    check("m3_rx", r_rx, 8'h96);
    check("m3_lat", r_lat, 68);
    check("m3_cslow", r_cs_low, 68);
    check("m3_gmin", r_gmin, 4);
    check("m3_gmax", r_gmax, 4);
    check("m3_edges", r_edges, 16);
    check("m3_sclk_end", r_sclk_end, 1'b1);
    check("m3_sclk_idle", sclk, 1'b1);

    // Mode 1, LSB first.
    run_xfer(1'b0, 1'b1, 1'b0, 8'd0, 8'h01, 8'h35, 1'b0, -1);
    check("m1_mosi", r_mosi, 8'h80);
    check("m1_rx", r_rx, 8'h35);
    check("m1_lat", r_lat, 20);
    check("m1_sclk_end", r_sclk_end, 1'b0);

    // Mode 2, LSB first, divider 2.
    run_xfer(1'b1, 1'b0, 1'b0, 8'd2, 8'h01, 8'hC6, 1'b0, -1);
    check("m2_first", r_first, 1'b1);
    check("m2_mosi", r_mosi, 8'h80);
    check("m2_rx", r_rx, 8'hC6);
    check("m2_lat", r_lat, 52);
    check("m2_sclk_end", r_sclk_end, 1'b1);

    // Inputs scrambled and start pulsed mid-transfer: no effect, nothing queued.
    run_xfer(1'b0, 1'b0, 1'b1, 8'd1, 8'h5A, 8'hC3, 1'b0, 10);
    check("chg_mosi", r_mosi, 8'h5A);
    check("chg_rx", r_rx, 8'hC3);
    check("chg_lat", r_lat, 36);
    check("chg_gmin", r_gmin, 2);
    check("chg_gmax", r_gmax, 2);
    check("chg_edges", r_edges, 16);
    check("chg_sclk_end", r_sclk_end, 1'b0);
    repeat (3) @(negedge pclk);
    check("chg_noqueue_ready", ready, 1'b1);
    check("chg_noqueue_cs", cs, 1'b1);

    // start held high: back-to-back transfers.
    sl_cpol = 1'b0; sl_cpha = 1'b0; sl_msb = 1'b1; sl_loop = 1'b1;
    cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1; baud_div = 8'd0; tx_data = 8'h69;
    @(negedge pclk);
    start = 1'b1;
    @(posedge pclk);
    vcnt = 0; v1 = -1; v2 = -1; cs_hi = 0; rx2 = 8'h00;
    for (int t = 0; t <= 45; t++) begin
      @(negedge pclk);
      if (cs) cs_hi++;
      if (rx_valid) begin
        vcnt++;
        if (vcnt == 1) v1 = t;
        if (vcnt == 2) begin v2 = t; rx2 = rx_data; end
      end
    end
    start = 1'b0;
    check("b2b_vcnt", vcnt, 2);
    check("b2b_v1", v1, 20);
    check("b2b_v2", v2, 42);
    check("b2b_cshigh", cs_hi, 4);
    check("b2b_rx", rx2, 8'h69);
    $display("xfer back-to-back tx=69 valid_at=%0d,%0d cs_high=%0d", v1, v2, cs_hi);
    for (int i = 0; i < 100 && !ready; i++) @(negedge pclk);
    check("b2b_drain", ready, 1'b1);

    // Reset at the 5th sclk edge.
    sl_loop = 1'b1; cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1; baud_div = 8'd1; tx_data = 8'h77;
    @(negedge pclk);
    start = 1'b1;
    @(posedge pclk);
    prev = 1'b0; edges = 0;
    for (int t = 0; t < 200 && edges < 5; t++) begin
      @(negedge pclk);
      if (t == 0) start = 1'b0;
      if (sclk != prev) begin prev = sclk; edges++; end
    end
    check("rst5_edge", edges, 5);
    areset = 1'b1;
    #1;
    check("rst5_cs", cs, 1'b1);
    check("rst5_sclk", sclk, 1'b0);
    check("rst5_ready", ready, 1'b1);
    check("rst5_mosi", mosi0, 1'b0);
    check("rst5_rxd", rx_data, 8'h00);
    @(negedge pclk);
    areset = 1'b0;
    vcnt = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge pclk);
      if (rx_valid) vcnt++;
    end
    check("rst5_novalid", vcnt, 0);
    $display("xfer aborted by reset at edge %0d", edges);

    // Fresh transfer after reset.
    run_xfer(1'b0, 1'b0, 1'b1, 8'd0, 8'h3C, 8'h00, 1'b1, -1);
    check("post_rx", r_rx, 8'h3C);
    check("post_lat", r_lat, 20);
    check("post_vcnt", r_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
